// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - handshake/data bundle for shift_sequencer.
// The rot signal exists only when SHIFT_SEQ_ROTATE_EN is defined.
interface shift_sequencer_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N);

  logic          start;
  logic [N-1:0]  data_in;
  logic [AW-1:0] amt;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic          rot;
`endif
  logic          ready;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;

`ifdef SHIFT_SEQ_ROTATE_EN
  modport master (
    output start, data_in, amt, rot,
    input  ready, busy, done, data_out
  );

  modport slave (
    input  start, data_in, amt, rot,
    output ready, busy, done, data_out
  );
`else
  modport master (
    output start, data_in, amt,
    input  ready, busy, done, data_out
  );

  modport slave (
    input  start, data_in, amt,
    output ready, busy, done, data_out
  );
`endif
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle left shifter, one bit per clock.
// Optional rotate mode selected at build time with SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  data_q;
  logic [AW-1:0] cnt;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          fill;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q;

  assign fill = rot_q & data_q[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      rot_q <= bus.rot;
    end
  end
`else
  assign fill = 1'b0;
`endif

  // Exit on cnt <= 1 so a zero count can never wrap and stall in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_q  <= bus.data_in;
            cnt     <= bus.amt;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.amt == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
              done_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data_q <= {data_q[N-2:0], fill};
          if (cnt <= AW'(1)) begin
            cnt    <= '0;
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cnt    <= cnt - AW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer (N=8).
// Rotate vectors are compiled in when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_sequencer;
  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;
  logic prev_done;

  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];

  shift_sequencer_if #(.N(8)) bus ();

  shift_sequencer #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_data_q.size() == 0) begin
        total++;
        $display("FAIL spurious_done actual=data_out %0h required=no done", bus.data_out);
      end else begin
        check("done_data", bus.data_out, exp_data_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
        check("busy_in_done", bus.busy, 1);
        check("done_width", prev_done, 0);
      end
    end
    prev_done = rst ? 1'b0 : bus.done;
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) check("ready_timeout", bus.ready, 1);
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic r);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amt     = a;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.rot     = r;
`else
    if (r) $display("rotate requested without rotate build");
`endif
  endtask

  task automatic do_op(input logic [7:0] d, input logic [2:0] a, input logic r,
                       input bit hold, input logic [7:0] exp);
    int bc = 0;
    int t  = 0;
    wait_ready();
    drive(d, a, r);
    @(posedge clk);
    #1;
    exp_data_q.push_back(exp);
    exp_cyc_q.push_back(cyc + int'(a));
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    while (!bus.ready && t < 100) begin
      if (bus.busy) bc++;
      if (hold && bus.done) bus.start = 1'b0;
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    check("busy_cycles", bc, int'(a) + 1);
    check("ready_after", bus.ready, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_data_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("sb_drained", exp_data_q.size(), 0);
  endtask

  initial begin
    total = 0; passed = 0; prev_done = 1'b0;
    bus.start = 1'b0; bus.data_in = '0; bus.amt = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.rot = 1'b0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'hB5, 3'd3, 1'b0, 1'b0, 8'hA8);
    do_op(8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A);
    do_op(8'h01, 3'd7, 1'b0, 1'b1, 8'h80);
    do_op(8'hC3, 3'd4, 1'b0, 1'b0, 8'h30);
    drain();
    check("hold_idle_data", bus.data_out, 8'h30);

    // Reset in the middle of SHIFT, two edges after acceptance.
    wait_ready();
    drive(8'hFF, 3'd5, 1'b0);
    @(posedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_data_out", bus.data_out, 0);
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    exp_data_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h03, 3'd1, 1'b0, 1'b0, 8'h06);

    // Start held from the DONE cycle into IDLE: only the IDLE edge accepts.
    begin
      int t = 0;
      wait_ready();
      drive(8'h3C, 3'd2, 1'b0);
      @(posedge clk);
      #1;
      exp_data_q.push_back(8'hF0);
      exp_cyc_q.push_back(cyc + 2);
      bus.start = 1'b0;
      @(negedge clk);
      while (!bus.done && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("b2b_done_seen", bus.done, 1);
      drive(8'h81, 3'd1, 1'b0);
      @(posedge clk);
      #1;
      check("b2b_done_start_ignored", bus.ready, 1);
      @(posedge clk);
      #1;
      check("b2b_idle_start_taken", bus.busy, 1);
      exp_data_q.push_back(8'h02);
      exp_cyc_q.push_back(cyc + 1);
      bus.start = 1'b0;
      drain();
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    do_op(8'hB5, 3'd3, 1'b1, 1'b0, 8'hAD);
    do_op(8'hB5, 3'd3, 1'b0, 1'b0, 8'hA8);
    do_op(8'h81, 3'd1, 1'b1, 1'b0, 8'h03);
`endif
    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
